// File: rtl/jtcps1_eeprom_pkg.sv
// Shared constants for the 93C46-style serial EEPROM responder: opcodes,
// extended sub-codes, FSM state and pending-commit encodings.
package jtcps1_eeprom_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Sub-codes carried in the two address MSBs when the opcode is OP_EXT
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD,
        ST_WR,
        ST_WAIT,
        ST_BUSY
    } state_t;

    typedef enum logic [2:0] {
        CM_NONE,
        CM_WRITE,
        CM_ERASE,
        CM_ERAL,
        CM_WRAL
    } commit_t;

endpackage

// File: rtl/jtcps1_eeprom_if.sv
// EEPROM bus bundle: serial CPU pins, parallel dump port and FSM debug state.
interface jtcps1_eeprom_if #(parameter int AW = 6);
    import jtcps1_eeprom_pkg::*;

    // No valid/ready pairs here: scs frames a serial transaction and every
    // sclk rise inside it moves one bit; dump_we/dump_clr are one-cycle strobes
    // acted on at the clock edge they are high for, and dump_dout always shows
    // mem[dump_addr] as it was one clock earlier.
    logic          scs;
    logic          sclk;
    logic          sdi;
    logic          sdo;
    logic [AW-1:0] dump_addr;
    logic [15:0]   dump_din;
    logic          dump_we;
    logic [15:0]   dump_dout;
    logic          dump_clr;
    logic          dump_flag;
    state_t        dbg_state;

    modport master (
        output scs, sclk, sdi, dump_addr, dump_din, dump_we, dump_clr,
        input  sdo, dump_dout, dump_flag, dbg_state
    );

    modport slave (
        input  scs, sclk, sdi, dump_addr, dump_din, dump_we, dump_clr,
        output sdo, dump_dout, dump_flag, dbg_state
    );

endinterface

// File: rtl/jtcps1_eeprom_mem.sv
// 2**AW x 16 dual-port word store. Serial port reads old data on a write;
// a parallel write in the same cycle as a serial write is dropped.
module jtcps1_eeprom_mem #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] s_addr,
    input  logic [15:0]   s_din,
    input  logic          s_we,
    output logic [15:0]   s_dout,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_din,
    input  logic          d_we,
    output logic [15:0]   d_dout
);

    logic [15:0] mem [0:2**AW-1];

    always_ff @(posedge clk) begin
        s_dout <= mem[s_addr];
        if (s_we)
            mem[s_addr] <= s_din;
        else if (d_we)
            mem[d_addr] <= d_din;
    end

    always_ff @(posedge clk) begin
        if (rst)
            d_dout <= 16'd0;
        else
            d_dout <= mem[d_addr];
    end

endmodule

// File: rtl/jtcps1_eeprom_93c.sv
// Serial EEPROM responder (93C46 x16) answering the CPS1 CPU on sdo, with a
// parallel dump port so the loader can restore and save the contents.
module jtcps1_eeprom_93c
    import jtcps1_eeprom_pkg::*;
#(
    parameter int          AW        = 6,
    parameter logic [15:0] WRITE_DLY = 16'd2000
) (
    input  logic           clk,
    input  logic           rst,
    jtcps1_eeprom_if.slave bus
);

    localparam int            CW       = AW + 2;
    localparam logic [4:0]    CMD_LAST = 5'(CW - 1);
    localparam logic [4:0]    WORD_LAST = 5'd15;
    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        state;
    commit_t       commit;
    logic          sclk_l;
    logic [CW-2:0] cmd_sr;
    logic [4:0]    bit_cnt;
    logic [AW-1:0] addr;
    logic [15:0]   data_sr;
    logic [1:0]    ld_pend;
    logic          wen;
    logic          sdo_r;
    logic [15:0]   busy_cnt;
    logic          sweep_act;
    logic [AW-1:0] sweep_idx;
    logic          wr_req;
    logic [15:0]   wr_data;
    logic          chk_q;
    logic [15:0]   chk_din;
    logic          flag;

    logic          rise;
    logic [CW-1:0] cmd_nx;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [15:0]   s_dout;

    assign rise   = bus.sclk & ~sclk_l;
    assign cmd_nx = {cmd_sr, bus.sdi};
    assign s_addr = sweep_act ? sweep_idx : addr;
    assign s_we   = wr_req | sweep_act;

    assign bus.sdo       = sdo_r;
    assign bus.dump_flag = flag;
    assign bus.dbg_state = state;

    jtcps1_eeprom_mem #(.AW(AW)) u_mem (
        .clk    (clk),
        .rst    (rst),
        .s_addr (s_addr),
        .s_din  (wr_data),
        .s_we   (s_we),
        .s_dout (s_dout),
        .d_addr (bus.dump_addr),
        .d_din  (bus.dump_din),
        .d_we   (bus.dump_we),
        .d_dout (bus.dump_dout)
    );

    always_ff @(posedge clk) begin
        sclk_l <= bus.sclk;
        if (rst) begin
            state     <= ST_IDLE;
            commit    <= CM_NONE;
            cmd_sr    <= '0;
            bit_cnt   <= 5'd0;
            addr      <= '0;
            data_sr   <= 16'd0;
            ld_pend   <= 2'd0;
            wen       <= 1'b0;
            sdo_r     <= 1'b1;
            busy_cnt  <= 16'd0;
            sweep_act <= 1'b0;
            sweep_idx <= '0;
            wr_req    <= 1'b0;
            wr_data   <= 16'd0;
            chk_q     <= 1'b0;
            chk_din   <= 16'd0;
            flag      <= 1'b0;
        end else begin
            wr_req <= 1'b0;

            // Bulk writes sweep one word per clock while the busy timer runs
            if (sweep_act) begin
                sweep_idx <= sweep_idx + ADDR_ONE;
                if (sweep_idx == ADDR_MAX)
                    sweep_act <= 1'b0;
            end

            // Read data arrives two clocks after the address register moves
            if (ld_pend != 2'd0) begin
                ld_pend <= ld_pend - 2'd1;
                if (ld_pend == 2'd1)
                    data_sr <= s_dout;
            end

            // s_dout holds the pre-write word the cycle after a serial write
            chk_q   <= s_we;
            chk_din <= wr_data;
            if (bus.dump_clr)
                flag <= 1'b0;
            else if (chk_q && chk_din != s_dout)
                flag <= 1'b1;

            case (state)
                ST_IDLE: begin
                    sdo_r <= 1'b1;
                    if (bus.scs && rise && bus.sdi) begin
                        state   <= ST_CMD;
                        commit  <= CM_NONE;
                        bit_cnt <= 5'd0;
                        cmd_sr  <= '0;
                    end
                end

                ST_CMD: begin
                    if (!bus.scs) begin
                        state   <= ST_IDLE;
                        cmd_sr  <= '0;
                        bit_cnt <= 5'd0;
                        sdo_r   <= 1'b1;
                    end else if (rise) begin
                        cmd_sr  <= cmd_nx[CW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == CMD_LAST) begin
                            addr    <= cmd_nx[AW-1:0];
                            bit_cnt <= 5'd0;
                            case (cmd_nx[CW-1:CW-2])
                                OP_READ: begin
                                    state   <= ST_RD;
                                    sdo_r   <= 1'b0;
                                    ld_pend <= 2'd2;
                                end
                                OP_WRITE: begin
                                    state  <= ST_WR;
                                    commit <= CM_WRITE;
                                end
                                OP_ERASE: begin
                                    state  <= ST_WAIT;
                                    commit <= CM_ERASE;
                                end
                                OP_EXT: begin
                                    state <= ST_WAIT;
                                    case (cmd_nx[AW-1:AW-2])
                                        EXT_EWEN: wen <= 1'b1;
                                        EXT_EWDS: wen <= 1'b0;
                                        EXT_ERAL: commit <= CM_ERAL;
                                        EXT_WRAL: begin
                                            commit <= CM_WRAL;
                                            state  <= ST_WR;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end

                ST_RD: begin
                    if (!bus.scs) begin
                        state   <= ST_IDLE;
                        data_sr <= 16'd0;
                        bit_cnt <= 5'd0;
                        ld_pend <= 2'd0;
                        sdo_r   <= 1'b1;
                    end else if (rise) begin
                        sdo_r   <= data_sr[15];
                        data_sr <= {data_sr[14:0], 1'b0};
                        if (bit_cnt == WORD_LAST) begin
                            bit_cnt <= 5'd0;
                            addr    <= addr + ADDR_ONE;
                            ld_pend <= 2'd2;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                ST_WR: begin
                    if (!bus.scs) begin
                        state   <= ST_IDLE;
                        data_sr <= 16'd0;
                        bit_cnt <= 5'd0;
                        sdo_r   <= 1'b1;
                    end else if (rise) begin
                        data_sr <= {data_sr[14:0], bus.sdi};
                        if (bit_cnt == WORD_LAST) begin
                            state   <= ST_WAIT;
                            bit_cnt <= 5'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!bus.scs) begin
                        sdo_r   <= 1'b1;
                        data_sr <= 16'd0;
                        if (commit != CM_NONE && wen) begin
                            state    <= ST_BUSY;
                            busy_cnt <= WRITE_DLY;
                            case (commit)
                                CM_WRITE: begin
                                    wr_req  <= 1'b1;
                                    wr_data <= data_sr;
                                end
                                CM_ERASE: begin
                                    wr_req  <= 1'b1;
                                    wr_data <= 16'hFFFF;
                                end
                                CM_ERAL: begin
                                    sweep_act <= 1'b1;
                                    sweep_idx <= '0;
                                    wr_data   <= 16'hFFFF;
                                end
                                CM_WRAL: begin
                                    sweep_act <= 1'b1;
                                    sweep_idx <= '0;
                                    wr_data   <= data_sr;
                                end
                                default: ;
                            endcase
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_BUSY: begin
                    sdo_r <= ~bus.scs;
                    if (busy_cnt == 16'd0) begin
                        state <= ST_IDLE;
                        sdo_r <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt - 16'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_eeprom_93c.sv
// Directed bench for jtcps1_eeprom_93c: bit-banged serial commands from the
// CPU side plus dump-port loads/reads, checked against hand-computed words.
module tb_jtcps1_eeprom_93c;
  import jtcps1_eeprom_pkg::*;

  localparam int          AW  = 6;
  localparam logic [15:0] DLY = 16'd200;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  jtcps1_eeprom_if #(.AW(AW)) bus ();

  jtcps1_eeprom_93c #(.AW(AW), .WRITE_DLY(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.sclk = 1'b0;
    bus.sdi  = b;
    tick(4);
    bus.sclk = 1'b1;
    tick(4);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [5:0] a);
    bus.scs = 1'b1;
    tick(2);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    for (int i = 5; i >= 0; i--) send_bit(a[i]);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic read_word(output logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      send_bit(1'b0);
      w[i] = bus.sdo;
    end
  endtask

  task automatic end_cmd();
    bus.sclk = 1'b0;
    bus.sdi  = 1'b0;
    bus.scs  = 1'b0;
    tick(2);
  endtask

  task automatic dump_wr(input logic [5:0] a, input logic [15:0] d);
    bus.dump_addr = a;
    bus.dump_din  = d;
    bus.dump_we   = 1'b1;
    tick(1);
    bus.dump_we   = 1'b0;
  endtask

  task automatic dump_rd(input logic [5:0] a, output logic [15:0] d);
    bus.dump_addr = a;
    tick(2);
    d = bus.dump_dout;
  endtask

  task automatic clear_flag();
    bus.dump_clr = 1'b1;
    tick(1);
    bus.dump_clr = 1'b0;
    tick(1);
  endtask

  // Polls the busy indication with scs high; bounded so a stuck device ends the run
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    bus.scs = 1'b1;
    tick(2);
    checks++;
    if (bus.sdo !== 1'b0) $display("FAIL %s_busy: sdo=%b expected 0", name, bus.sdo);
    else passed++;
    while (bus.sdo !== 1'b1 && n < int'(DLY) + 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (n < int'(DLY) - 10 || n > int'(DLY) + 5)
      $display("FAIL %s_ready: busy lasted %0d cycles, expected %0d..%0d", name, n, int'(DLY) - 10, int'(DLY) + 5);
    else passed++;
    bus.scs = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.scs = 1'b0; bus.sclk = 1'b0; bus.sdi = 1'b0;
    bus.dump_addr = '0; bus.dump_din = 16'd0; bus.dump_we = 1'b0; bus.dump_clr = 1'b0;
    tick(5);
    checks++;
    if (bus.dump_dout !== 16'd0) $display("FAIL reset_dout: got %h expected 0000", bus.dump_dout);
    else passed++;
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus.sdo !== 1'b1) $display("FAIL reset_sdo: got %b expected 1", bus.sdo);
    else passed++;
    checks++;
    if (bus.dump_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", bus.dump_flag);
    else passed++;
    checks++;
    if (bus.dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
    else passed++;
  endtask

  task automatic test_read();
    logic [15:0] w;
    dump_wr(6'd5, 16'hA55A);
    dump_wr(6'd6, 16'h0F0F);
    dump_rd(6'd5, w);
    checks++;
    if (w !== 16'hA55A) $display("FAIL dump_read5: got %h expected a55a", w);
    else passed++;
    start_cmd(OP_READ, 6'd5);
    checks++;
    if (bus.sdo !== 1'b0) $display("FAIL read_dummy: got %b expected 0", bus.sdo);
    else passed++;
    read_word(w);
    checks++;
    if (w !== 16'hA55A) $display("FAIL read_word5: got %h expected a55a", w);
    else passed++;
    read_word(w);
    checks++;
    if (w !== 16'h0F0F) $display("FAIL read_seq6: got %h expected 0f0f", w);
    else passed++;
    end_cmd();
    checks++;
    if (bus.sdo !== 1'b1) $display("FAIL read_end_sdo: got %b expected 1", bus.sdo);
    else passed++;
  endtask

  task automatic test_write_protected();
    logic [15:0] w;
    dump_wr(6'd3, 16'hBEEF);
    start_cmd(OP_WRITE, 6'd3);
    send_word(16'h1234);
    end_cmd();
    tick(3);
    checks++;
    if (bus.dbg_state !== ST_IDLE) $display("FAIL wp_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
    else passed++;
    dump_rd(6'd3, w);
    checks++;
    if (w !== 16'hBEEF) $display("FAIL wp_mem: got %h expected beef", w);
    else passed++;
    checks++;
    if (bus.dump_flag !== 1'b0) $display("FAIL wp_flag: got %b expected 0", bus.dump_flag);
    else passed++;
  endtask

  task automatic test_write();
    logic [15:0] w;
    start_cmd(OP_EXT, 6'b110000);
    end_cmd();
    start_cmd(OP_WRITE, 6'd3);
    send_word(16'h1234);
    end_cmd();
    wait_ready("write");
    dump_rd(6'd3, w);
    checks++;
    if (w !== 16'h1234) $display("FAIL write_mem: got %h expected 1234", w);
    else passed++;
    checks++;
    if (bus.dump_flag !== 1'b1) $display("FAIL write_flag: got %b expected 1", bus.dump_flag);
    else passed++;
    clear_flag();
    checks++;
    if (bus.dump_flag !== 1'b0) $display("FAIL write_clr: got %b expected 0", bus.dump_flag);
    else passed++;
  endtask

  task automatic test_eral_wral();
    logic [15:0] w;
    int bad;
    start_cmd(OP_EXT, 6'b110000);
    end_cmd();
    start_cmd(OP_EXT, 6'b100000);
    end_cmd();
    wait_ready("eral");
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      dump_rd(6'(i), w);
      if (w !== 16'hFFFF) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL eral_all: %0d words differ, expected 0 (ffff everywhere)", bad);
    else passed++;
    checks++;
    if (bus.dump_flag !== 1'b1) $display("FAIL eral_flag: got %b expected 1", bus.dump_flag);
    else passed++;
    clear_flag();
    start_cmd(OP_EXT, 6'b010000);
    send_word(16'h0000);
    end_cmd();
    wait_ready("wral");
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      dump_rd(6'(i), w);
      if (w !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL wral_all: %0d words differ, expected 0 (0000 everywhere)", bad);
    else passed++;
    checks++;
    if (bus.dump_flag !== 1'b1) $display("FAIL wral_flag: got %b expected 1", bus.dump_flag);
    else passed++;
    // Distinct end words so the wrap from 63 to 0 is visible
    dump_wr(6'd63, 16'h8001);
    dump_wr(6'd0, 16'h7E3C);
    start_cmd(OP_READ, 6'd63);
    read_word(w);
    checks++;
    if (w !== 16'h8001) $display("FAIL read_word63: got %h expected 8001", w);
    else passed++;
    read_word(w);
    checks++;
    if (w !== 16'h7E3C) $display("FAIL read_wrap0: got %h expected 7e3c", w);
    else passed++;
    end_cmd();
  endtask

  task automatic test_abort();
    logic [15:0] w;
    bus.scs = 1'b1;
    tick(2);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    end_cmd();
    checks++;
    if (bus.sdo !== 1'b1) $display("FAIL abort_sdo: got %b expected 1", bus.sdo);
    else passed++;
    checks++;
    if (bus.dbg_state !== ST_IDLE) $display("FAIL abort_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
    else passed++;
    start_cmd(OP_READ, 6'd63);
    checks++;
    if (bus.sdo !== 1'b0) $display("FAIL abort_dummy: got %b expected 0", bus.sdo);
    else passed++;
    read_word(w);
    checks++;
    if (w !== 16'h8001) $display("FAIL abort_reread: got %h expected 8001", w);
    else passed++;
    end_cmd();
  endtask

  task automatic test_collision();
    logic [15:0] w;
    start_cmd(OP_WRITE, 6'd3);
    send_word(16'h5A5A);
    bus.sclk = 1'b0;
    bus.sdi  = 1'b0;
    bus.scs  = 1'b0;
    // Commit is latched on the next edge; the memory write lands on the one after
    @(negedge clk);
    bus.dump_addr = 6'd3;
    bus.dump_din  = 16'hDEAD;
    bus.dump_we   = 1'b1;
    @(negedge clk);
    bus.dump_we   = 1'b0;
    wait_ready("collide");
    dump_rd(6'd3, w);
    checks++;
    if (w !== 16'h5A5A) $display("FAIL collide_mem: got %h expected 5a5a", w);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_read();
    test_write_protected();
    test_write();
    test_eral_wral();
    test_abort();
    test_collision();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
